// File: rtl/vga_vram_arbiter_if.sv
// Bundle of display-fetch, host-write and RAM-side signals around the VRAM arbiter.
// The arbiter takes the slave view; the sync generator, host writer and RAM take the master view.
interface vga_vram_arbiter_if #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic              video_on;
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_valid;
  logic              disp_overrun;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  video_on, disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
    output disp_data, disp_valid, disp_overrun, wr_ack, mem_addr, mem_we, mem_wdata
  );

  modport master (
    output video_on, disp_req, disp_addr, wr_req, wr_addr, wr_data, mem_rdata,
    input  disp_data, disp_valid, disp_overrun, wr_ack, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: display fetches always win, host writes fill idle slots
// (blanking only unless WR_IN_ACTIVE is set).
module vga_vram_arbiter #(
  parameter int ADDR_W       = 12,
  parameter int DATA_W       = 8,
  parameter bit WR_IN_ACTIVE = 1'b0
) (
  input  logic                clk_i,
  input  logic                reset_i,
  vga_vram_arbiter_if.slave   arb
);

  typedef enum logic [1:0] {IDLE, RD, RD_CAP, WR} state_t;

  state_t              state_q, state_d;
  logic                disp_pend_q, disp_pend_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                overrun_q, overrun_d;
  logic [DATA_W-1:0]   disp_data_q, disp_data_d;
  logic                disp_valid_q, disp_valid_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                mem_we_c;
  logic                wr_ack_c;
  logic                wr_allowed;

  assign wr_allowed = ~arb.video_on | WR_IN_ACTIVE;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      disp_pend_q  <= 1'b0;
      rd_addr_q    <= '0;
      overrun_q    <= 1'b0;
      disp_data_q  <= '0;
      disp_valid_q <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      disp_pend_q  <= disp_pend_d;
      rd_addr_q    <= rd_addr_d;
      overrun_q    <= overrun_d;
      disp_data_q  <= disp_data_d;
      disp_valid_q <= disp_valid_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    disp_pend_d  = disp_pend_q;
    rd_addr_d    = rd_addr_q;
    overrun_d    = overrun_q;
    disp_data_d  = disp_data_q;
    disp_valid_d = 1'b0;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_we_c     = 1'b0;
    wr_ack_c     = 1'b0;

    // A newer request always replaces an unserved one; losing the old one is flagged.
    if (arb.disp_req) begin
      rd_addr_d   = arb.disp_addr;
      disp_pend_d = 1'b1;
      if (disp_pend_q) begin
        overrun_d = 1'b1;
      end
    end

    case (state_q)
      IDLE: begin
        if (disp_pend_q || arb.disp_req) begin
          state_d = RD;
        end else if (arb.wr_req && wr_allowed) begin
          state_d = WR;
        end
      end
      RD: begin
        // A request landing during RD is served by this very access.
        mem_addr_d  = arb.disp_req ? arb.disp_addr : rd_addr_q;
        disp_pend_d = 1'b0;
        state_d     = RD_CAP;
      end
      RD_CAP: begin
        disp_data_d  = arb.mem_rdata;
        disp_valid_d = 1'b1;
        state_d      = IDLE;
      end
      WR: begin
        mem_addr_d  = arb.wr_addr;
        mem_wdata_d = arb.wr_data;
        mem_we_c    = 1'b1;
        wr_ack_c    = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address/data follow the current access and hold their last value otherwise.
  assign arb.mem_addr     = mem_addr_d;
  assign arb.mem_wdata    = mem_wdata_d;
  assign arb.mem_we       = mem_we_c;
  assign arb.wr_ack       = wr_ack_c;
  assign arb.disp_data    = disp_data_q;
  assign arb.disp_valid   = disp_valid_q;
  assign arb.disp_overrun = overrun_q;

  a_wr_single_cycle: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == WR) |=> (state_q == IDLE));
  a_valid_after_cap: assert property (@(posedge clk_i) disable iff (reset_i)
    (state_q == RD_CAP) |=> disp_valid_q);

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter: bench RAM, shadow memory model, read/write expectation queues.
module tb_vga_vram_arbiter;
  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 8;
  localparam bit WR_IN_ACT = 1'b0;
  localparam int DEPTH     = 1 << ADDR_W;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    int                cyc;
  } rexp_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wexp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vga_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  vga_vram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .WR_IN_ACTIVE(WR_IN_ACT)) dut (
    .clk_i   (clk),
    .reset_i (rst),
    .arb     (bus)
  );

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [DATA_W-1:0] ram    [DEPTH];
  logic [DATA_W-1:0] shadow [DEPTH];
  logic load_en = 1'b0;

  rexp_t rq[$];
  wexp_t wq[$];
  bit    sb_en        = 1'b0;
  bit    exp_overrun  = 1'b0;
  bit    prev_req     = 1'b0;
  bit    prev_video   = 1'b0;
  bit    rand_done    = 1'b0;
  int    ack_cnt      = 0;
  int    last_ack_cyc = 0;
  int    last_val_cyc = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    checks++;
    if (act < lo || act > hi) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d..%0d (cycle %0d)", nm, act, lo, hi, cyc);
    end
  endtask

  // Bench RAM: synchronous, one-cycle read latency, read-before-write.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= shadow[i];
    end else if (bus.mem_we) begin
      ram[bus.mem_addr] <= bus.mem_wdata;
    end
    bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Reference model: completed writes update the shadow; each fetch expects the
  // shadow contents at request time. A fetch followed one cycle later by another
  // is superseded by it and counts as an overrun.
  always @(negedge clk) begin
    rexp_t e;
    if (sb_en) begin
      if (bus.wr_ack) begin
        shadow[bus.wr_addr] = bus.wr_data;
        ack_cnt++;
        last_ack_cyc = cyc;
      end
      if (bus.disp_req) begin
        e.addr = bus.disp_addr;
        e.data = shadow[bus.disp_addr];
        e.cyc  = cyc;
        if (prev_req && rq.size() > 0) begin
          e.cyc = rq[rq.size()-1].cyc;
          void'(rq.pop_back());
          exp_overrun = 1'b1;
        end
        rq.push_back(e);
      end
      prev_req = bus.disp_req;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a read result or a write.
  always @(negedge clk) begin
    rexp_t r;
    wexp_t w;
    if (sb_en) begin
      if (bus.disp_valid) begin
        last_val_cyc = cyc;
        if (rq.size() == 0) begin
          chk("disp_valid_unexpected", 1, 0);
        end else begin
          r = rq.pop_front();
          chk($sformatf("disp_data@%0h", r.addr), bus.disp_data, r.data);
          chk_rng("disp_latency", cyc - r.cyc, 3, 4);
        end
      end
      if (bus.mem_we || bus.wr_ack) begin
        chk("we_ack_together", {bus.mem_we, bus.wr_ack}, 2'b11);
        if (!WR_IN_ACT) chk("write_in_blanking", prev_video, 0);
        if (wq.size() == 0) begin
          chk("write_unexpected", 1, 0);
        end else begin
          w = wq.pop_front();
          chk("mem_addr_wr", bus.mem_addr, w.addr);
          chk("mem_wdata", bus.mem_wdata, w.data);
        end
      end
      prev_video = bus.video_on;
    end
  end

  task automatic host_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d, input bit keep);
    wexp_t w;
    int n;
    w.addr = a;
    w.data = d;
    wq.push_back(w);
    @(posedge clk); #1;
    bus.wr_req  = 1'b1;
    bus.wr_addr = a;
    bus.wr_data = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wr_ack && n < 3000);
    if (!bus.wr_ack) begin
      chk("wr_ack_timeout", 0, 1);
      void'(wq.pop_back());
      keep = 1'b0;
    end
    if (!keep) begin
      @(posedge clk); #1;
      bus.wr_req = 1'b0;
    end
  endtask

  task automatic disp_pulse(input logic [ADDR_W-1:0] a);
    @(posedge clk); #1;
    bus.disp_req  = 1'b1;
    bus.disp_addr = a;
    @(posedge clk); #1;
    bus.disp_req  = 1'b0;
  endtask

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int vcyc;
    int base;
    bus.video_on  = 1'b0;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.wr_req    = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    for (int i = 0; i < DEPTH; i++) shadow[i] = DATA_W'($urandom);
    shadow[12'h123] = 8'hA5;
    shadow[12'h055] = 8'h11;
    shadow[12'h010] = 8'h00;
    shadow[12'h011] = 8'h66;
    shadow[12'h200] = 8'h11;
    shadow[12'h201] = 8'h22;
    load_en = 1'b1;
    @(posedge clk); #1;
    load_en = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_mem_we", bus.mem_we, 0);
    chk("rst_disp_valid", bus.disp_valid, 0);
    chk("rst_vector", {bus.disp_data, bus.disp_overrun, bus.wr_ack, bus.mem_addr, bus.mem_wdata}, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during a write cycle aborts it at once.
    bus.wr_req  = 1'b1;
    bus.wr_addr = 12'h055;
    bus.wr_data = 8'h77;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.mem_we && n < 10);
    chk("t1_reached_wr", bus.mem_we, 1);
    rst = 1'b1;
    #1;
    chk("t1_we_async_drop", bus.mem_we, 0);
    chk("t1_ack_async_drop", bus.wr_ack, 0);
    bus.wr_req = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("t1_post_outputs", {bus.disp_data, bus.disp_valid, bus.disp_overrun, bus.wr_ack,
                            bus.mem_addr, bus.mem_we, bus.mem_wdata}, 0);
    chk("t1_ram_untouched", ram[12'h055], 8'h11);
    sb_en = 1'b1;

    // Single fetch on an idle bus.
    disp_pulse(12'h123);
    @(negedge clk);
    chk("t2_mem_addr_n1", bus.mem_addr, 12'h123);
    chk("t2_no_we", bus.mem_we, 0);
    repeat (6) @(posedge clk);

    // Write held off during active video, granted after video_on falls.
    bus.video_on = 1'b1;
    base = ack_cnt;
    vcyc = 0;
    fork
      host_write(12'h010, 8'h3C, 1'b0);
      begin
        repeat (20) @(posedge clk);
        #1;
        chk("t3_no_ack_active", ack_cnt - base, 0);
        bus.video_on = 1'b0;
        vcyc = cyc;
      end
    join
    repeat (2) @(posedge clk);
    chk("t3_ack_first_idle", last_ack_cyc - vcyc, 1);
    chk("t3_ram_written", ram[12'h010], 8'h3C);

    // Simultaneous fetch and write: read of the old value first, then the write.
    fork
      host_write(12'h011, 8'h5A, 1'b0);
      disp_pulse(12'h011);
    join
    repeat (6) @(posedge clk);
    chk_rng("t4_wr_after_rd", last_ack_cyc - last_val_cyc, 0, 1);
    chk("t4_overrun", bus.disp_overrun, exp_overrun);
    chk("t4_ram", ram[12'h011], 8'h5A);

    // Two lines of 1-in-4 fetches with a continuously busy host writer.
    fork
      begin
        for (int s = 0; s < 400; s++) begin
          @(posedge clk); #1;
          bus.video_on  = ((s % 200) < 160);
          bus.disp_req  = ($urandom_range(0, 3) != 0);
          bus.disp_addr = ($urandom_range(0, 7) == 0) ? ADDR_W'($urandom) : ADDR_W'($urandom_range(0, 15));
          @(posedge clk); #1;
          bus.disp_req = 1'b0;
          repeat (2) @(posedge clk);
        end
        #1;
        bus.video_on = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) host_write(ADDR_W'($urandom_range(0, 15)), DATA_W'($urandom), 1'b1);
        @(posedge clk); #1;
        bus.wr_req = 1'b0;
      end
    join
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t5_overrun", bus.disp_overrun, exp_overrun);
    chk("t5_reads_drained", rq.size(), 0);

    // Back-to-back fetches one cycle apart: second address wins, overrun sticks.
    @(posedge clk); #1;
    bus.disp_req  = 1'b1;
    bus.disp_addr = 12'h200;
    @(posedge clk); #1;
    bus.disp_addr = 12'h201;
    @(posedge clk); #1;
    bus.disp_req = 1'b0;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("t6_overrun_set", bus.disp_overrun, exp_overrun);
    chk("t6_overrun_one", bus.disp_overrun, 1);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("t6_overrun_sticky", bus.disp_overrun, 1);
    chk("final_reads_drained", rq.size(), 0);
    chk("final_writes_drained", wq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
